// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the digit-serial add/subtract engine.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;

    typedef logic req_id_t;

endpackage

// File: rtl/addsub_seq_if.sv
// Requester-side bus of addsub_seq: two request channels plus the shared result.
interface addsub_seq_if #(
    parameter int W = 8
);
    import addsub_seq_pkg::*;

    logic           req0;
    logic           req1;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           m0;
    logic           m1;
    logic           ack0;
    logic           ack1;
    logic           busy;
    logic           done;
    req_id_t        done_id;
    logic [W-1:0]   result;
    logic           cout;
    logic           ovf;

    modport master (
        output req0, req1, a0, b0, a1, b1, m0, m1,
        input  ack0, ack1, busy, done, done_id, result, cout, ovf
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, m0, m1,
        output ack0, ack1, busy, done, done_id, result, cout, ovf
    );

endinterface

// File: rtl/addsub_slice.sv
// Combinational 2-bit add slice: two chained full adders, b arrives pre-inverted for subtract.
module addsub_slice
    import addsub_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic c_mid;

    assign s[0]  = a[0] ^ b[0] ^ cin;
    assign c_mid = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    assign s[1]  = a[1] ^ b[1] ^ c_mid;
    assign cout  = (a[1] & b[1]) | (c_mid & (a[1] ^ b[1]));

endmodule

// File: rtl/addsub_seq.sv
// Round-robin shared add/subtract engine that walks one 2-bit slice across the operands,
// one digit per clock, and reports result, carry-out and signed overflow.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    addsub_seq_if.slave bus
);

    localparam int DIGITS = W / DIGIT_W;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    req_id_t         rr_last_q, rr_last_d;
    req_id_t         id_q, id_d;
    req_id_t         done_id_q, done_id_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            carry_q, carry_d;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] s_dig;
    logic               slice_cout;

    logic            any_req;
    req_id_t         gid;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic            m_sel;

    // Select the digit currently addressed by k from the latched operands.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == KW'(i)) begin
                a_dig = a_q[DIGIT_W*i +: DIGIT_W];
                b_dig = b_q[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

    addsub_slice u_slice (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .s    (s_dig),
        .cout (slice_cout)
    );

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        gid     = (bus.req0 & bus.req1) ? ~rr_last_q : bus.req1;
        a_sel   = gid ? bus.a1 : bus.a0;
        b_sel   = gid ? bus.b1 : bus.b0;
        m_sel   = gid ? bus.m1 : bus.m0;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done_d    = 1'b0;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        carry_d   = carry_q;

        case (state_q)
            IDLE, DONE: begin
                if (any_req) begin
                    a_d       = a_sel;
                    b_d       = b_sel ^ {W{m_sel}};
                    carry_d   = m_sel;
                    rr_last_d = gid;
                    id_d      = gid;
                    ack0_d    = ~gid;
                    ack1_d    = gid;
                    k_d       = '0;
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (k_q == KW'(i)) begin
                        acc_d[DIGIT_W*i +: DIGIT_W] = s_dig;
                    end
                end
                carry_d = slice_cout;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // Top digit: the slice sees a[W-1], b'[W-1] and produces sum[W-1].
                    result_d  = acc_d;
                    cout_d    = slice_cout;
                    ovf_d     = (a_q[W-1] == b_q[W-1]) && (s_dig[DIGIT_W-1] != a_q[W-1]);
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            rr_last_q <= 1'b1;
            id_q      <= 1'b0;
            done_id_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
        end
    end

    // Operand and accumulator storage is always reloaded at grant, so it needs no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        acc_q   <= acc_d;
        carry_q <= carry_d;
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed test-plan cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_addsub_seq;

    localparam int W      = 8;
    localparam int DIGITS = W / 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    addsub_seq_if #(.W(W)) bus ();

    addsub_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout, ovf, result} from plain unsigned/signed integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit m);
        int ua = int'(a);
        int ub = int'(b);
        int sa = a[W-1] ? ua - 2**W : ua;
        int sb = b[W-1] ? ub - 2**W : ub;
        int ur = m ? ua - ub : ua + ub;
        int sr = m ? sa - sb : sa + sb;
        logic [W-1:0] r = ur[W-1:0];
        logic c = m ? (ua >= ub) : (ur >= 2**W);
        logic o = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
        return {c, o, r};
    endfunction

    task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit m);
        if (id) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.m1 = m;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.m0 = m;
        end
    endtask

    task automatic drop(input bit id);
        if (id) bus.req1 = 1'b0;
        else    bus.req0 = 1'b0;
    endtask

    // Called in the ack cycle; runs to the done cycle and checks the result there.
    task automatic finish_op(input string tag, input bit id, input bit keep,
                             input logic [W-1:0] er, input bit ec, input bit eo);
        if (!keep) drop(id);
        for (int i = 1; i < DIGITS; i++) begin
            tick();
            check({tag, "_done_early"}, bus.done, 1'b0);
        end
        tick();
        check({tag, "_done"},    bus.done,    1'b1);
        check({tag, "_done_id"}, bus.done_id, id);
        check({tag, "_result"},  bus.result,  er);
        check({tag, "_cout"},    bus.cout,    ec);
        check({tag, "_ovf"},     bus.ovf,     eo);
        check({tag, "_busy"},    bus.busy,    1'b1);
    endtask

    task automatic run_single(input string tag, input bit id, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit m,
                              input logic [W-1:0] er, input bit ec, input bit eo);
        drive(id, a, b, m);
        tick();
        check({tag, "_ack"},   id ? bus.ack1 : bus.ack0, 1'b1);
        check({tag, "_noack"}, id ? bus.ack0 : bus.ack1, 1'b0);
        finish_op(tag, id, 1'b0, er, ec, eo);
        tick();
        check({tag, "_idle_done"}, bus.done, 1'b0);
        check({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack0"},    bus.ack0,    1'b0);
        check({tag, "_ack1"},    bus.ack1,    1'b0);
        check({tag, "_done"},    bus.done,    1'b0);
        check({tag, "_busy"},    bus.busy,    1'b0);
        check({tag, "_done_id"}, bus.done_id, 1'b0);
        check({tag, "_result"},  bus.result,  '0);
        check({tag, "_cout"},    bus.cout,    1'b0);
        check({tag, "_ovf"},     bus.ovf,     1'b0);
    endtask

    initial begin
        logic [W+1:0] exp;
        logic [W-1:0] ra, rb;
        bit           rid, rm;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.m0 = 1'b0;
        bus.a1 = '0; bus.b1 = '0; bus.m1 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
        check_outputs_zero("post_reset");

        run_single("add",      1'b0, 8'h25, 8'h17, 1'b0, 8'h3C, 1'b0, 1'b0);
        run_single("sub_brw",  1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_single("ovf_pos",  1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_single("carry",    1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_single("ovf_neg",  1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Contention straight after reset: requester 0 wins the first tie.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(1'b0, 8'h11, 8'h22, 1'b0);
        drive(1'b1, 8'h50, 8'h05, 1'b1);
        tick();
        check("cont_ack0", bus.ack0, 1'b1);
        check("cont_ack1_wait", bus.ack1, 1'b0);
        finish_op("cont_op0", 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
        check("cont_ack1_busy", bus.ack1, 1'b0);
        tick();
        check("cont_ack1", bus.ack1, 1'b1);
        check("cont_done_gap", bus.done, 1'b0);
        finish_op("cont_op1", 1'b1, 1'b0, 8'h4B, 1'b1, 1'b0);
        drive(1'b0, 8'h01, 8'h02, 1'b0);
        drive(1'b1, 8'h03, 8'h04, 1'b0);
        tick();
        check("cont3_ack0", bus.ack0, 1'b1);
        check("cont3_ack1_wait", bus.ack1, 1'b0);
        finish_op("cont_op2", 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
        tick();
        check("cont3_ack1", bus.ack1, 1'b1);
        finish_op("cont_op3", 1'b1, 1'b0, 8'h07, 1'b0, 1'b0);
        tick();
        check("cont_idle", bus.busy, 1'b0);

        // Held request: req0 stays high across two operations.
        drive(1'b0, 8'h40, 8'h02, 1'b0);
        tick();
        check("held_ack_a", bus.ack0, 1'b1);
        bus.a0 = 8'h09;
        bus.b0 = 8'h03;
        bus.m0 = 1'b1;
        finish_op("held_op_a", 1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        tick();
        check("held_ack_b", bus.ack0, 1'b1);
        check("held_hold_result", bus.result, 8'h42);
        finish_op("held_op_b", 1'b0, 1'b0, 8'h06, 1'b1, 1'b0);
        tick();
        check("held_idle", bus.busy, 1'b0);

        // Reset at k=2 aborts the operation without a done.
        drive(1'b1, 8'h33, 8'h44, 1'b0);
        tick();
        check("abort_ack", bus.ack1, 1'b1);
        drop(1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_outputs_zero("abort_async");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2 * DIGITS; i++) begin
            tick();
            check("abort_no_done", bus.done, 1'b0);
        end
        run_single("abort_retry", 1'b1, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rid = 1'($urandom_range(0, 1));
            rm  = 1'($urandom_range(0, 1));
            ra  = W'($urandom);
            rb  = W'($urandom);
            exp = model(ra, rb, rm);
            run_single($sformatf("rand%0d", n), rid, ra, rb, rm,
                       exp[W-1:0], exp[W+1], exp[W]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
